lzd_norm_shift: RTL and testbench
=================================

// Module: lzd_norm_shift
// PURPOSE
//  Normalizing left shifter: the consumer end of the leading-zero-detect path.
//  - Takes an operand plus its leading-zero count, as produced by an LZD block.
//  - Shifts the operand left so its MSB is 1, using an iterative log shifter
//    (one binary stage per clock).
//  - Sits after the LZD in the FP add/normalize datapath; valid/ready on both sides.
// PARAMETERS
//  WIDTH  16  operand width; must be a power of 2
//  CW     4   count width = log2(WIDTH)
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      reset: synchronous, active-high
//  in_valid   in   1      input item valid
//  in_ready   out  1      block can accept an input item
//  in_data    in   WIDTH  operand to normalize
//  in_lzc     in   CW     leading-zero count of in_data; bit WIDTH-1 is counted first
//  in_zero    in   1      in_data is all zeros (in_lzc is don't-care)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_data   out  WIDTH  normalized operand
//  out_lzc    out  CW     echo of the captured in_lzc (exponent adjust)
//  out_zero   out  1      echo of the captured in_zero
//  out_err    out  1      normalization check flag (see CONFIGURATION)
// BEHAVIOUR
//  FSM states: IDLE, SHIFT, HOLD.
//  - in_ready = 1 only in IDLE.
//  - out_valid = 1 only in HOLD.
//  Reset: state = IDLE and stage index k = 0. All outputs 0 except in_ready = 1.
//  IDLE: when in_valid = 1, capture in_data, in_lzc and in_zero, set k = 0, go to SHIFT.
//  SHIFT, one stage per cycle:
//  - If lzc[k] = 1, data <= data << (1 << k), zero-filled; otherwise data is unchanged.
//  - Stages run in order k = 0..CW-1, so the shifts are 1, 2, 4, 8.
//  - After stage CW-1, go to HOLD.
//  Latency: an item accepted at edge T gives out_valid = 1 after edge T+CW
//  (4 cycles at default).
//  HOLD:
//  - out_data, out_lzc and out_zero stay stable while out_ready = 0.
//  - When out_valid and out_ready are both 1, go to IDLE.
//    in_ready rises the following cycle; there is no same-cycle re-accept.
//  - Throughput: at most one item per CW+2 cycles.
//  in_zero = 1: no stage shifts, whatever in_lzc says.
//  - out_data = in_data, which is expected to be 0.
//  - out_zero = 1.
//  - Latency is the same as for a nonzero operand.
//  Inputs other than in_valid are ignored outside IDLE.
//  in_lzc >= WIDTH cannot be encoded and needs no handling.
//  rst asserted in any state: the in-flight item is dropped. Next cycle:
//  state = IDLE, in_ready = 1, out_valid = 0, datapath registers = 0.
// CONFIGURATION
//  NORM_CHECK_EN defined:
//  - On the edge that enters HOLD, out_err is set to (!zero & !data[WIDTH-1]),
//    i.e. the LZD count was wrong.
//  - out_err is valid with out_valid and clears on leaving HOLD.
//  NORM_CHECK_EN undefined: out_err is tied to 0 and no check logic is built.
// TESTING
//  1. in_data=16'h0001, lzc=15 -> 4 cycles later out_valid=1, out_data=16'h8000, out_lzc=15
//  2. in_data=16'h0F30, lzc=4 -> out_data=16'hF300, out_zero=0
//  3. in_zero=1, in_data=0, lzc=9 -> out_data=16'h0000, out_zero=1, latency 4
//  4. out_ready=0 for 3 cycles in HOLD -> out_data stable, in_ready=0; accept on cycle 4 -> in_ready=1 next cycle
//  5. rst=1 in the 2nd SHIFT cycle -> next cycle out_valid=0, in_ready=1; the next item completes normally
//  6. NORM_CHECK_EN defined: in_data=16'h0100, lzc=3 -> out_data=16'h0800, out_err=1; with lzc=7 -> out_err=0

Source files
------------

// File: rtl/lzd_norm_shift.sv
// ============================================================================
// lzd_norm_shift
// Normalizing left shifter fed by a leading-zero detector. The captured
// operand is shifted left by its leading-zero count using an iterative log
// shifter: one binary stage (shift by 1, 2, 4, ...) per clock, so an accepted
// item is presented on the output CW cycles later and held until taken.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input item valid
//   in_ready   out  block can accept an input item (IDLE only)
//   in_data    in   operand to normalize
//   in_lzc     in   leading-zero count of in_data
//   in_zero    in   in_data is all zeros; suppresses every shift stage
//   out_valid  out  result valid (HOLD only)
//   out_ready  in   downstream accepts the result
//   out_data   out  normalized operand
//   out_lzc    out  captured leading-zero count (exponent adjust)
//   out_zero   out  captured zero flag
//   out_err    out  normalization check flag
//
// Optional feature macro: NORM_CHECK_EN
//   defined   : out_err flags a result whose MSB is not 1 for a nonzero operand
//   undefined : out_err is tied to 0 and no check logic is built
// ============================================================================
module lzd_norm_shift #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_lzc,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_lzc,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_lzc;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_stage_data;
    logic             w_last_stage;

    assign w_last_stage = (r_k == CW'(CW - 1));

    // One log-shifter stage: shift by 2^k when count bit k is set
    always_comb begin
        w_stage_data = r_data;
        if (!r_zero && r_lzc[r_k]) begin
            w_stage_data = r_data << (WIDTH'(1) << r_k);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)     w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_stage) w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready)    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_HOLD);
        end
    end

    // Datapath: capture in IDLE, one shift stage per SHIFT cycle, hold in HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_lzc  <= '0;
            r_zero <= 1'b0;
            r_k    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_lzc  <= in_lzc;
                        r_zero <= in_zero;
                        r_k    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_stage_data;
                    r_k    <= r_k + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef NORM_CHECK_EN
    logic r_err;

    // Judge the final stage result as HOLD is entered; clear on release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_SHIFT && w_last_stage) begin
            r_err <= !r_zero && !w_stage_data[WIDTH-1];
        end else if (r_state == S_HOLD && out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign out_lzc   = r_lzc;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_lzd_norm_shift.sv
module tb_lzd_norm_shift;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    lzc;
        logic             zero;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_lzc;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_lzc;
    logic             out_zero;
    logic             out_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    lzd_norm_shift #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lzc    (in_lzc),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a full left shift by the count, or no shift for a zero operand
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [CW-1:0] l,
                                   input logic z);
        exp_t e;
        e.data = z ? d : (d << l);
        e.lzc  = l;
        e.zero = z;
`ifdef NORM_CHECK_EN
        e.err  = !z && !e.data[WIDTH-1];
`else
        e.err  = 1'b0;
`endif
        return e;
    endfunction

    // Drive one item; returns after the accepting edge (+1)
    task automatic send(input logic [WIDTH-1:0] d, input logic [CW-1:0] l, input logic z,
                        input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_lzc = l; in_zero = z;
        if (push) sb.push_back(model(d, l, z));
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '1; in_lzc = '1; in_zero = 1'b0;
    endtask

    // Wait for the result, check latency and payload, stall, then release
    task automatic receive(input int stall);
        int   n = 0;
        exp_t e;
        logic [WIDTH-1:0] held;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(CW));
        check("in_ready_in_hold", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_lzc",  32'(out_lzc),  32'(e.lzc));
        check("out_zero", 32'(out_zero), 32'(e.zero));
        check("out_err",  32'(out_err),  32'(e.err));
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(out_data),  32'(held));
            check("stall_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready),  32'd1);
        check("release_err",   32'(out_err),   32'd0);
    endtask

    initial begin
        logic [CW-1:0]    rl;
        logic [WIDTH-1:0] rd;
        logic [WIDTH-1:0] top;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_lzc = '0; in_zero = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_lzc",   32'(out_lzc),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);

        // Directed items, including the worst-case full shift
        send(16'h0001, 4'd15, 1'b0, 1'b1); receive(0);
        check("t1_data_const", 32'(out_data), 32'h8000);
        send(16'h0F30, 4'd4,  1'b0, 1'b1); receive(0);
        send(16'h8001, 4'd0,  1'b0, 1'b1); receive(0);
        send(16'h0000, 4'd9,  1'b1, 1'b1); receive(0);
        check("t3_zero_data", 32'(out_data), 32'h0000);

        // Stall for 3 cycles in HOLD
        send(16'h0123, 4'd7, 1'b0, 1'b1); receive(3);

        // Reset during the second SHIFT cycle drops the item
        send(16'h00F0, 4'd8, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_data",  32'(out_data),  32'd0);
        repeat (6) @(posedge clk);
        #1 check("midrst_no_valid", 32'(out_valid), 32'd0);
        send(16'h00F0, 4'd8, 1'b0, 1'b1); receive(1);

        // Wrong and right counts for the normalization check
        send(16'h0100, 4'd3, 1'b0, 1'b1); receive(0);
        check("t6_wrong_data", 32'(out_data), 32'h0800);
        send(16'h0100, 4'd7, 1'b0, 1'b1); receive(0);

        // Random operands with consistent counts
        for (int i = 0; i < 8; i++) begin
            rl  = CW'($urandom_range(0, WIDTH - 1));
            top = 16'h8000 >> rl;
            rd  = top | (16'($urandom) & (top - 16'd1));
            send(rd, rl, 1'b0, 1'b1); receive(i % 3);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
